// File: rtl/dense_layer_sequencer_if.sv
// Control bundle between the dense-layer sequencer and its network top / datapath.
// SEQUENCER_PERF_EN adds the last_job_cycles performance counter signal.
interface dense_layer_sequencer_if #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned NUM_MACS    = 4
);
  localparam int unsigned NumGroups = NUM_NEURONS / NUM_MACS;
  localparam int unsigned IdxW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned WaW  = (NumGroups * NUM_INPUTS > 1) ? $clog2(NumGroups * NUM_INPUTS) : 1;
  localparam int unsigned NbW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic            inputs_ready;
  logic            busy;
  logic            mac_clear;
  logic            mac_enable;
  logic            bias_enable;
  logic [IdxW-1:0] input_index;
  logic [WaW-1:0]  weight_address;
  logic [NbW-1:0]  neuron_base;
  logic            output_write;
  logic            outputs_ready;
`ifdef SEQUENCER_PERF_EN
  logic [15:0]     last_job_cycles;
`endif

  modport master (
`ifdef SEQUENCER_PERF_EN
    output last_job_cycles,
`endif
    input  inputs_ready,
    output busy, mac_clear, mac_enable, bias_enable, input_index, weight_address,
    output neuron_base, output_write, outputs_ready
  );

  modport slave (
`ifdef SEQUENCER_PERF_EN
    input  last_job_cycles,
`endif
    output inputs_ready,
    input  busy, mac_clear, mac_enable, bias_enable, input_index, weight_address,
    input  neuron_base, output_write, outputs_ready
  );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Sequences one dense layer over NUM_MACS shared MAC lanes, one neuron group at a time.
// SEQUENCER_PERF_EN adds a saturating busy-cycle count of the last completed job.
module dense_layer_sequencer #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned NUM_MACS    = 4,
  parameter int unsigned MAC_LATENCY = 2
) (
  input logic clock,
  input logic reset,
  dense_layer_sequencer_if.master bus
);
  localparam int unsigned NumGroups = NUM_NEURONS / NUM_MACS;
  localparam int unsigned IdxW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned GrpW = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam int unsigned WaW  = (NumGroups * NUM_INPUTS > 1) ? $clog2(NumGroups * NUM_INPUTS) : 1;
  localparam int unsigned NbW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned LatW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_INPUTS - 1);
  localparam logic [GrpW-1:0] GrpLast = GrpW'(NumGroups - 1);
  localparam logic [LatW-1:0] LatLast = LatW'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    StIdle, StAccumulate, StBias, StDrain, StWrite, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [GrpW-1:0] group_q, group_d;
  logic [IdxW-1:0] index_q, index_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic            ir_q;
  logic            start;

  logic            busy_q, busy_d, ready_q, ready_d;
  logic            clear_q, clear_d, enable_q, enable_d;
  logic            bias_q, bias_d, write_q, write_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [WaW-1:0]  wa_q, wa_d;
  logic [NbW-1:0]  nb_q, nb_d;

  // ir_q resets low, so inputs_ready held high across reset release starts a job.
  assign start = bus.inputs_ready & ~ir_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      group_q  <= '0;
      index_q  <= '0;
      lat_q    <= '0;
      ir_q     <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      clear_q  <= 1'b0;
      enable_q <= 1'b0;
      bias_q   <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      wa_q     <= '0;
      nb_q     <= '0;
    end else begin
      state_q  <= state_d;
      group_q  <= group_d;
      index_q  <= index_d;
      lat_q    <= lat_d;
      ir_q     <= bus.inputs_ready;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      clear_q  <= clear_d;
      enable_q <= enable_d;
      bias_q   <= bias_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      wa_q     <= wa_d;
      nb_q     <= nb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    index_d = index_q;
    lat_d   = lat_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          group_d = '0;
          index_d = '0;
          state_d = StAccumulate;
        end
      end
      StAccumulate: begin
        if (index_q == IdxLast) begin
          index_d = '0;
          state_d = StBias;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
      StBias: begin
        lat_d   = '0;
        state_d = (MAC_LATENCY == 0) ? StWrite : StDrain;
      end
      StDrain: begin
        if (lat_q == LatLast) state_d = StWrite;
        else                  lat_d   = lat_q + 1'b1;
      end
      StWrite: begin
        if (group_q == GrpLast) begin
          state_d = StDone;
        end else begin
          group_d = group_q + 1'b1;
          state_d = StAccumulate;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that the flops present them as Moore outputs.
  always_comb begin
    busy_d   = state_d inside {StAccumulate, StBias, StDrain, StWrite};
    ready_d  = (state_d == StDone);
    enable_d = (state_d == StAccumulate);
    clear_d  = enable_d && (index_d == '0);
    bias_d   = (state_d == StBias);
    write_d  = (state_d == StWrite);
    idx_d    = enable_d ? index_d : '0;
    wa_d     = enable_d ? (WaW'(group_d) * WaW'(NUM_INPUTS) + WaW'(index_d)) : '0;
    nb_d     = write_d ? (NbW'(group_d) * NbW'(NUM_MACS)) : '0;
  end

  assign bus.busy           = busy_q;
  assign bus.outputs_ready  = ready_q;
  assign bus.mac_clear      = clear_q;
  assign bus.mac_enable     = enable_q;
  assign bus.bias_enable    = bias_q;
  assign bus.output_write   = write_q;
  assign bus.input_index    = idx_q;
  assign bus.weight_address = wa_q;
  assign bus.neuron_base    = nb_q;

`ifdef SEQUENCER_PERF_EN
  logic [15:0] job_cnt_q, job_cnt_d, last_q, last_d;

  always_comb begin
    job_cnt_d = job_cnt_q;
    last_d    = last_q;
    if (busy_d) begin
      if (!busy_q)                     job_cnt_d = 16'd1;
      else if (job_cnt_q != 16'hFFFF) job_cnt_d = job_cnt_q + 16'd1;
    end
    if (state_d == StDone && state_q != StDone) last_d = job_cnt_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      job_cnt_q <= '0;
      last_q    <= '0;
    end else begin
      job_cnt_q <= job_cnt_d;
      last_q    <= last_d;
    end
  end

  assign bus.last_job_cycles = last_q;
`endif
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer: default build plus a one-input, one-group instance.
module tb_dense_layer_sequencer;
  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  dense_layer_sequencer_if #(.NUM_INPUTS(16), .NUM_NEURONS(16), .NUM_MACS(4)) bus ();
  dense_layer_sequencer #(
    .NUM_INPUTS(16), .NUM_NEURONS(16), .NUM_MACS(4), .MAC_LATENCY(2)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  dense_layer_sequencer_if #(.NUM_INPUTS(1), .NUM_NEURONS(4), .NUM_MACS(4)) sbus ();
  dense_layer_sequencer #(
    .NUM_INPUTS(1), .NUM_NEURONS(4), .NUM_MACS(4), .MAC_LATENCY(0)
  ) u_small (
    .clock(clock),
    .reset(reset),
    .bus  (sbus)
  );

  // {busy, outputs_ready, mac_clear, mac_enable, bias_enable, output_write, idx, addr, base}
  logic [19:0] obs;
  logic [9:0]  sobs;
  assign obs  = {bus.busy, bus.outputs_ready, bus.mac_clear, bus.mac_enable, bus.bias_enable,
                 bus.output_write, bus.input_index, bus.weight_address, bus.neuron_base};
  assign sobs = {sbus.busy, sbus.outputs_ready, sbus.mac_clear, sbus.mac_enable,
                 sbus.bias_enable, sbus.output_write, sbus.input_index, sbus.weight_address,
                 sbus.neuron_base};

  localparam logic [19:0] DoneVec = 20'h40000;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Cycle k of a default job: 20-cycle groups of 16 accumulate, bias, 2 drain, write.
  function automatic logic [19:0] exp_job(input int k);
    int         g = k / 20;
    int         r = k % 20;
    logic       clr = 1'b0, en = 1'b0, bi = 1'b0, wr = 1'b0;
    logic [3:0] idx = '0;
    logic [5:0] wa  = '0;
    logic [3:0] nb  = '0;
    if (r < 16) begin
      en  = 1'b1;
      clr = (r == 0);
      idx = 4'(r);
      wa  = 6'(g * 16 + r);
    end else if (r == 16) begin
      bi = 1'b1;
    end else if (r == 19) begin
      wr = 1'b1;
      nb = 4'(g * 4);
    end
    return {1'b1, 1'b0, clr, en, bi, wr, idx, wa, nb};
  endfunction

  // Called just after a negedge with inputs_ready already raised for the start.
  task automatic run_job(input string tag, input int drop_at, input int rise_at, input int abort_at,
                         output int n_en, output int n_clr, output int n_wr);
    n_en  = 0;
    n_clr = 0;
    n_wr  = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      check($sformatf("%s_cyc%0d", tag, k), 32'(obs), 32'(exp_job(k)));
      n_en  += int'(bus.mac_enable);
      n_clr += int'(bus.mac_clear);
      n_wr  += int'(bus.output_write);
      if (k == drop_at) bus.inputs_ready = 1'b0;
      if (k == rise_at) bus.inputs_ready = 1'b1;
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check($sformatf("%s_async_abort", tag), 32'(obs), 32'd0);
        return;
      end
    end
    @(negedge clock);
    check($sformatf("%s_done_at_80", tag), 32'(obs), 32'(DoneVec));
  endtask

  initial begin
    int n_en, n_clr, n_wr;
    reset             = 1'b1;
    bus.inputs_ready  = 1'b0;
    sbus.inputs_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_main", 32'(obs), 32'd0);
    check("reset_small", 32'(sobs), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_main", 32'(obs), 32'd0);

    // One input, one group, no drain: accumulate, bias, write, done.
    sbus.inputs_ready = 1'b1;
    @(negedge clock);
    check("small_acc", 32'(sobs), 32'h2C0);
    @(negedge clock);
    check("small_bias", 32'(sobs), 32'h220);
    @(negedge clock);
    check("small_write", 32'(sobs), 32'h210);
    @(negedge clock);
    check("small_done", 32'(sobs), 32'h100);
    @(negedge clock);
    check("small_done_hold", 32'(sobs), 32'h100);

    // Job A: single rise, held high through DONE.
    bus.inputs_ready = 1'b1;
    run_job("jobA", -1, -1, -1, n_en, n_clr, n_wr);
    check("jobA_mac_enable_cycles", 32'(n_en), 32'd64);
    check("jobA_mac_clear_count", 32'(n_clr), 32'd4);
    check("jobA_output_write_count", 32'(n_wr), 32'd4);
`ifdef SEQUENCER_PERF_EN
    check("jobA_last_job_cycles", 32'(bus.last_job_cycles), 32'd80);
`endif
    repeat (10) @(negedge clock);
    check("held_high_no_restart", 32'(obs), 32'(DoneVec));
    bus.inputs_ready = 1'b0;
    @(negedge clock);
    check("done_after_fall", 32'(obs), 32'(DoneVec));

    // Job B: restart by toggle; fall at 10 and second rise at 30 are ignored.
    bus.inputs_ready = 1'b1;
    run_job("jobB", 10, 30, -1, n_en, n_clr, n_wr);
    check("jobB_mac_enable_cycles", 32'(n_en), 32'd64);
    repeat (5) @(negedge clock);
    check("jobB_single_done", 32'(obs), 32'(DoneVec));

    // Job C: reset at cycle 40 aborts; stays idle with inputs_ready low.
    bus.inputs_ready = 1'b0;
    @(negedge clock);
    bus.inputs_ready = 1'b1;
    run_job("jobC", -1, -1, 40, n_en, n_clr, n_wr);
    bus.inputs_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("jobC_in_reset", 32'(obs), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("jobC_idle_after_release%0d", i), 32'(obs), 32'd0);
    end

    // Job D: inputs_ready already high when reset is released.
    reset            = 1'b1;
    bus.inputs_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_job("jobD", -1, -1, -1, n_en, n_clr, n_wr);
    check("jobD_output_write_count", 32'(n_wr), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
